// File: rtl/cbf_pkg.sv
// Shared constants for the counting-Bloom-filter controller: opcodes, FSM encoding,
// and parameter defaults.
package cbf_pkg;

  localparam int KEY_W_DEF  = 16;
  localparam int ADDR_W_DEF = 6;
  localparam int K_DEF      = 3;

  localparam logic [1:0] OP_QUERY  = 2'b00;
  localparam logic [1:0] OP_INSERT = 2'b01;
  localparam logic [1:0] OP_DELETE = 2'b10;
  localparam logic [1:0] OP_RSVD   = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HASH   = 3'd1,
    PROBE  = 3'd2,
    UPDATE = 3'd3,
    RESP   = 3'd4
  } state_t;

endpackage

// File: rtl/cbf_hash_gen.sv
// Three combinational hash functions mapping a request key onto counter-cell indices.
// The mixing uses key bits [15:0] and produces 6-bit indices.
module cbf_hash_gen
  import cbf_pkg::*;
#(
  parameter int KEY_W  = KEY_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic [KEY_W-1:0]  key,
  output logic [ADDR_W-1:0] h0,
  output logic [ADDR_W-1:0] h1,
  output logic [ADDR_W-1:0] h2
);

  logic [5:0] lo_s;
  logic [5:0] mid_s;
  logic [5:0] hi_s;
  logic [5:0] mix_s;
  logic [5:0] sum_s;

  // Slice the key into the fields the hashes combine; the sum wraps modulo 64.
  always_comb begin
    lo_s  = key[5:0];
    mid_s = key[11:6];
    hi_s  = key[15:10];
    mix_s = {key[15:12], key[1:0]};
    sum_s = lo_s + hi_s;
  end

  assign h0 = ADDR_W'(lo_s ^ mid_s);
  assign h1 = ADDR_W'(mid_s ^ mix_s);
  assign h2 = ADDR_W'(sum_s);

endmodule

// File: rtl/cbf_controller.sv
// Counting Bloom filter controller: hashes a key, probes K counter cells, then
// optionally increments/decrements them and returns a flagged response.
module cbf_controller
  import cbf_pkg::*;
#(
  parameter int KEY_W  = KEY_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int K      = K_DEF
) (
  input  logic              CLK,
  input  logic              rstb,
  input  logic              req_valid,
  input  logic [1:0]        req_op,
  input  logic [KEY_W-1:0]  req_key,
  output logic              req_ready,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_hit,
  output logic              resp_ovf,
  output logic              resp_err,
  output logic [ADDR_W-1:0] cnt_addr,
  output logic              cnt_we,
  output logic              cnt_inc,
  input  logic              cnt_zero,
  input  logic              cnt_of
);

  localparam logic [1:0] LAST_IDX = 2'(K - 1);

  state_t             state_r, state_s;
  logic [1:0]         op_r;
  logic [KEY_W-1:0]   key_r;
  logic [1:0]         idx_r, idx_s;
  logic [ADDR_W-1:0]  h0_r, h1_r, h2_r;
  logic [ADDR_W-1:0]  hg0_s, hg1_s, hg2_s;
  logic               any_zero_r, any_zero_s;
  logic               any_of_r, any_of_s;
  logic               zsum_s, osum_s;
  logic               latch_s, load_h_s;
  logic               hit_s, ovf_s, err_s, we_s, inc_s;
  logic [ADDR_W-1:0]  addr_s;

  cbf_hash_gen #(.KEY_W(KEY_W), .ADDR_W(ADDR_W)) u_hash (
    .key (key_r),
    .h0  (hg0_s),
    .h1  (hg1_s),
    .h2  (hg2_s)
  );

  function automatic logic [ADDR_W-1:0] sel_h(input logic [1:0] idx,
                                               input logic [ADDR_W-1:0] a,
                                               input logic [ADDR_W-1:0] b,
                                               input logic [ADDR_W-1:0] c);
    case (idx)
      2'd0:    sel_h = a;
      2'd1:    sel_h = b;
      default: sel_h = c;
    endcase
  endfunction

  // Next-state and next-output logic; outputs are registered, so each branch
  // prepares what the cell interface must show during the following cycle.
  always_comb begin
    state_s    = state_r;
    idx_s      = idx_r;
    any_zero_s = any_zero_r;
    any_of_s   = any_of_r;
    hit_s      = resp_hit;
    ovf_s      = resp_ovf;
    err_s      = resp_err;
    inc_s      = cnt_inc;
    we_s       = 1'b0;
    addr_s     = '0;
    latch_s    = 1'b0;
    load_h_s   = 1'b0;
    zsum_s     = any_zero_r | cnt_zero;
    osum_s     = any_of_r | cnt_of;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          latch_s    = 1'b1;
          idx_s      = 2'd0;
          any_zero_s = 1'b0;
          any_of_s   = 1'b0;
          hit_s      = 1'b0;
          ovf_s      = 1'b0;
          err_s      = 1'b0;
          if (req_op == OP_RSVD) begin
            state_s = RESP;
            err_s   = 1'b1;
          end else begin
            state_s = HASH;
          end
        end else begin
          state_s = IDLE;
        end
      end
      HASH: begin
        load_h_s = 1'b1;
        idx_s    = 2'd0;
        state_s  = PROBE;
        addr_s   = hg0_s;
      end
      PROBE: begin
        any_zero_s = zsum_s;
        any_of_s   = osum_s;
        if (idx_r == LAST_IDX) begin
          idx_s = 2'd0;
          case (op_r)
            OP_QUERY: begin
              state_s = RESP;
              hit_s   = ~zsum_s;
            end
            OP_INSERT: begin
              if (osum_s) begin
                state_s = RESP;
                ovf_s   = 1'b1;
              end else begin
                state_s = UPDATE;
                we_s    = 1'b1;
                inc_s   = 1'b1;
                addr_s  = h0_r;
              end
            end
            OP_DELETE: begin
              if (zsum_s) begin
                state_s = RESP;
                err_s   = 1'b1;
              end else begin
                state_s = UPDATE;
                we_s    = 1'b1;
                inc_s   = 1'b0;
                addr_s  = h0_r;
              end
            end
            default: begin
              state_s = RESP;
              err_s   = 1'b1;
            end
          endcase
        end else begin
          idx_s  = idx_r + 2'd1;
          addr_s = sel_h(idx_r + 2'd1, h0_r, h1_r, h2_r);
        end
      end
      UPDATE: begin
        if (idx_r == LAST_IDX) begin
          idx_s   = 2'd0;
          state_s = RESP;
          hit_s   = 1'b1;
        end else begin
          idx_s  = idx_r + 2'd1;
          we_s   = 1'b1;
          addr_s = sel_h(idx_r + 2'd1, h0_r, h1_r, h2_r);
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_s = IDLE;
          hit_s   = 1'b0;
          ovf_s   = 1'b0;
          err_s   = 1'b0;
        end else begin
          state_s = RESP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs; reset aborts any operation in flight.
  always_ff @(posedge CLK or posedge rstb) begin
    if (rstb) begin
      state_r    <= IDLE;
      op_r       <= 2'b00;
      key_r      <= '0;
      idx_r      <= 2'd0;
      h0_r       <= '0;
      h1_r       <= '0;
      h2_r       <= '0;
      any_zero_r <= 1'b0;
      any_of_r   <= 1'b0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_hit   <= 1'b0;
      resp_ovf   <= 1'b0;
      resp_err   <= 1'b0;
      cnt_addr   <= '0;
      cnt_we     <= 1'b0;
      cnt_inc    <= 1'b0;
    end else begin
      state_r    <= state_s;
      idx_r      <= idx_s;
      any_zero_r <= any_zero_s;
      any_of_r   <= any_of_s;
      if (latch_s) begin
        op_r  <= req_op;
        key_r <= req_key;
      end
      if (load_h_s) begin
        h0_r <= hg0_s;
        h1_r <= hg1_s;
        h2_r <= hg2_s;
      end
      req_ready  <= (state_s == IDLE);
      resp_valid <= (state_s == RESP);
      resp_hit   <= hit_s;
      resp_ovf   <= ovf_s;
      resp_err   <= err_s;
      cnt_addr   <= addr_s;
      cnt_we     <= we_s;
      cnt_inc    <= inc_s;
    end
  end

endmodule

// File: tb/tb_cbf_controller.sv
// Self-checking bench: a saturating 4-bit counter array answers the controller's
// probes, and a key-level reference model predicts flags, latency and cell writes.
module tb_cbf_controller;
  import cbf_pkg::*;

  logic        CLK = 1'b0;
  logic        rstb = 1'b1;
  logic        req_valid = 1'b0;
  logic [1:0]  req_op = 2'b00;
  logic [15:0] req_key = 16'h0000;
  logic        req_ready, resp_valid, resp_hit, resp_ovf, resp_err;
  logic        resp_ready = 1'b0;
  logic [5:0]  cnt_addr;
  logic        cnt_we, cnt_inc, cnt_zero, cnt_of;

  logic [3:0]  cells [64] = '{default: 4'd0};
  int          ref_cnt [64] = '{default: 0};
  logic        force_of_en = 1'b0;
  logic [5:0]  force_of_addr = 6'd0;
  logic [6:0]  we_log [$];
  logic [6:0]  exp_q [$];
  int          checks = 0;
  int          errors = 0;

  cbf_controller dut (
    .CLK(CLK), .rstb(rstb),
    .req_valid(req_valid), .req_op(req_op), .req_key(req_key), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_hit(resp_hit), .resp_ovf(resp_ovf), .resp_err(resp_err),
    .cnt_addr(cnt_addr), .cnt_we(cnt_we), .cnt_inc(cnt_inc),
    .cnt_zero(cnt_zero), .cnt_of(cnt_of)
  );

  always #5 CLK = ~CLK;

  assign cnt_zero = (cells[cnt_addr] == 4'd0);
  assign cnt_of   = (cells[cnt_addr] == 4'd15) || (force_of_en && cnt_addr == force_of_addr);

  // Counter-cell array behaviour plus a log of every write pulse.
  always @(posedge CLK) begin
    if (cnt_we) begin
      we_log.push_back({cnt_inc, cnt_addr});
      if (cnt_inc) cells[cnt_addr] <= (cells[cnt_addr] == 4'd15) ? 4'd15 : cells[cnt_addr] + 4'd1;
      else         cells[cnt_addr] <= (cells[cnt_addr] == 4'd0)  ? 4'd0  : cells[cnt_addr] - 4'd1;
    end
  end

  function automatic int hsh(input int key, input int i);
    int a, b, c, d;
    a = key % 64;
    b = (key / 64) % 64;
    c = (key / 1024) % 64;
    d = ((key / 4096) % 16) * 4 + (key % 4);
    if (i == 0)      hsh = a ^ b;
    else if (i == 1) hsh = b ^ d;
    else             hsh = (a + c) % 64;
  endfunction

  task automatic model(input int op, input int key, output int elat,
                       output logic ehit, output logic eovf, output logic eerr);
    int  h [3];
    bit  az, ao;
    exp_q.delete();
    ehit = 1'b0; eovf = 1'b0; eerr = 1'b0; az = 1'b0; ao = 1'b0;
    for (int i = 0; i < 3; i++) begin
      h[i] = hsh(key, i);
      if (ref_cnt[h[i]] == 0)  az = 1'b1;
      if (ref_cnt[h[i]] == 15) ao = 1'b1;
    end
    elat = 5;
    if (op == 0) ehit = !az;
    else if (op == 1 && ao) eovf = 1'b1;
    else if (op == 2 && az) eerr = 1'b1;
    else if (op == 3) begin elat = 1; eerr = 1'b1; end
    else begin
      elat = 8; ehit = 1'b1;
      for (int i = 0; i < 3; i++) begin
        exp_q.push_back({(op == 1) ? 1'b1 : 1'b0, 6'(h[i])});
        if (op == 1) ref_cnt[h[i]] = (ref_cnt[h[i]] == 15) ? 15 : ref_cnt[h[i]] + 1;
        else         ref_cnt[h[i]] = (ref_cnt[h[i]] == 0) ? 0 : ref_cnt[h[i]] - 1;
      end
    end
  endtask

  // Issue one request and return the observed latency and flags.
  task automatic send(input logic [1:0] op, input logic [15:0] key, output int lat,
                      output logic hit, output logic ovf, output logic err);
    int n;
    n = 0;
    while (!req_ready && n < 50) begin @(posedge CLK); #1; n++; end
    we_log.delete();
    req_valid = 1'b1; req_op = op; req_key = key;
    @(posedge CLK); #1;
    req_valid = 1'b0;
    lat = 1;
    while (lat < 20) begin
      @(negedge CLK);
      if (resp_valid) break;
      @(posedge CLK); #1;
      lat++;
    end
    hit = resp_hit; ovf = resp_ovf; err = resp_err;
    if (resp_valid) begin
      resp_ready = 1'b1;
      @(posedge CLK); #1;
      resp_ready = 1'b0;
    end else begin
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_reset();
    rstb = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if ({req_ready, resp_valid, resp_hit, resp_ovf, resp_err} !== 5'b10000) begin
      errors++; $display("FAIL reset_handshake got %b want 10000",
                         {req_ready, resp_valid, resp_hit, resp_ovf, resp_err});
    end
    checks++;
    if ({cnt_we, cnt_inc, cnt_addr} !== 8'h00) begin
      errors++; $display("FAIL reset_cell_if got %h want 00", {cnt_we, cnt_inc, cnt_addr});
    end
    rstb = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_single(input string name, input logic [1:0] op, input logic [15:0] key);
    int   lat, elat;
    logic hit, ovf, err, ehit, eovf, eerr;
    model(int'(op), int'(key), elat, ehit, eovf, eerr);
    send(op, key, lat, hit, ovf, err);
    checks++;
    if (lat !== elat || {hit, ovf, err} !== {ehit, eovf, eerr}) begin
      errors++; $display("FAIL %s_resp got lat=%0d flags=%b want lat=%0d flags=%b",
                         name, lat, {hit, ovf, err}, elat, {ehit, eovf, eerr});
    end
    checks++;
    if (we_log != exp_q) begin
      errors++; $display("FAIL %s_writes got %p want %p", name, we_log, exp_q);
    end
    checks++;
    for (int i = 0; i < 3; i++) begin
      if (int'(cells[hsh(int'(key), i)]) != ref_cnt[hsh(int'(key), i)]) begin
        errors++; $display("FAIL %s_cell%0d got %0d want %0d", name, i,
                           cells[hsh(int'(key), i)], ref_cnt[hsh(int'(key), i)]);
        break;
      end
    end
  endtask

  task automatic test_known_key();
    int   lat;
    logic hit, ovf, err;
    test_single("query_empty", OP_QUERY, 16'hABCD);
    test_single("delete_empty", OP_DELETE, 16'h1234);
    test_single("insert_1234", OP_INSERT, 16'h1234);
    checks++;
    if (we_log.size() != 3 || we_log[0] !== 7'h7C || we_log[1] !== 7'h4C || we_log[2] !== 7'h78) begin
      errors++; $display("FAIL insert_addrs got %p want 60,12,56 with inc", we_log);
    end
    test_single("query_1234", OP_QUERY, 16'h1234);
    checks++;
    if (cells[60] !== 4'd1 || cells[12] !== 4'd1 || cells[56] !== 4'd1) begin
      errors++; $display("FAIL insert_cells got %0d %0d %0d want 1 1 1", cells[60], cells[12], cells[56]);
    end
    test_single("delete_1234", OP_DELETE, 16'h1234);
    checks++;
    if (cells[60] !== 4'd0 || cells[12] !== 4'd0 || cells[56] !== 4'd0) begin
      errors++; $display("FAIL delete_cells got %0d %0d %0d want 0 0 0", cells[60], cells[12], cells[56]);
    end
    force_of_en = 1'b1; force_of_addr = 6'd12;
    send(OP_INSERT, 16'h1234, lat, hit, ovf, err);
    force_of_en = 1'b0;
    checks++;
    if (lat != 5 || {hit, ovf, err} !== 3'b010 || we_log.size() != 0) begin
      errors++; $display("FAIL ovf_abort got lat=%0d flags=%b writes=%0d want lat=5 flags=010 writes=0",
                         lat, {hit, ovf, err}, we_log.size());
    end
  endtask

  task automatic test_backpressure();
    req_valid = 1'b1; req_op = OP_RSVD; req_key = 16'h5555;
    @(posedge CLK); #1;
    req_valid = 1'b0;
    @(negedge CLK);
    checks++;
    if (resp_valid !== 1'b1 || {resp_hit, resp_ovf, resp_err} !== 3'b001) begin
      errors++; $display("FAIL rsvd_t1 got valid=%b flags=%b want valid=1 flags=001",
                         resp_valid, {resp_hit, resp_ovf, resp_err});
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK); @(negedge CLK);
      checks++;
      if (resp_valid !== 1'b1 || {resp_hit, resp_ovf, resp_err} !== 3'b001 || req_ready !== 1'b0) begin
        errors++; $display("FAIL hold_%0d got valid=%b flags=%b ready=%b want 1 001 0", i,
                           resp_valid, {resp_hit, resp_ovf, resp_err}, req_ready);
      end
    end
    resp_ready = 1'b1;
    @(posedge CLK); #1;
    resp_ready = 1'b0;
    @(negedge CLK);
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || {resp_hit, resp_ovf, resp_err} !== 3'b000) begin
      errors++; $display("FAIL release got valid=%b ready=%b flags=%b want 0 1 000",
                         resp_valid, req_ready, {resp_hit, resp_ovf, resp_err});
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_reset_mid_update();
    we_log.delete();
    req_valid = 1'b1; req_op = OP_INSERT; req_key = 16'h1234;
    @(posedge CLK); #1;
    req_valid = 1'b0;
    repeat (5) @(posedge CLK);
    #2;
    checks++;
    if (cnt_we !== 1'b1 || cnt_addr !== 6'd12) begin
      errors++; $display("FAIL upd2_setup got we=%b addr=%0d want we=1 addr=12", cnt_we, cnt_addr);
    end
    rstb = 1'b1;
    #1;
    checks++;
    if ({req_ready, resp_valid, resp_hit, resp_ovf, resp_err, cnt_we, cnt_inc} !== 7'b1000000 ||
        cnt_addr !== 6'd0) begin
      errors++; $display("FAIL midreset_outputs got %b addr=%0d want 1000000 addr=0",
                         {req_ready, resp_valid, resp_hit, resp_ovf, resp_err, cnt_we, cnt_inc}, cnt_addr);
    end
    @(negedge CLK);
    rstb = 1'b0;
    ref_cnt[60] = ref_cnt[60] + 1;
    @(posedge CLK); #1;
    checks++;
    if (we_log.size() != 1 || cells[60] !== 4'd1 || cells[12] !== 4'd0) begin
      errors++; $display("FAIL partial_update got writes=%0d c60=%0d c12=%0d want 1 1 0",
                         we_log.size(), cells[60], cells[12]);
    end
    test_single("after_reset_query", OP_QUERY, 16'h1234);
    test_single("after_reset_insert", OP_INSERT, 16'h1234);
  endtask

  task automatic test_random();
    logic [15:0] pool [6];
    logic [1:0]  op;
    for (int i = 0; i < 6; i++) pool[i] = 16'($urandom);
    for (int n = 0; n < 60; n++) begin
      op = ($urandom_range(0, 9) < 4) ? OP_INSERT : 2'($urandom_range(0, 3));
      test_single("random", op, pool[$urandom_range(0, 5)]);
    end
  endtask

  initial begin
    test_reset();
    test_known_key();
    test_backpressure();
    test_reset_mid_update();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cbf_controller.md
CBF_CONTROLLER -- requirements
Module: cbf_controller

Interface
REQ-001 Parameter KEY_W, default 16: request key width.
REQ-002 Parameter ADDR_W, default 6: counter-array index width (64 counter cells).
REQ-003 Parameter K, default 3: hash functions per key; only K=3 is supported.
REQ-004 CLK  input  1  sole clock, rising edge.
REQ-005 rstb  input  1  reset, asynchronous, active-high.
REQ-006 req_valid  input  1  request present.
REQ-007 req_op  input  2  request opcode: 00 query, 01 insert, 10 delete, 11 reserved.
REQ-008 req_key  input  KEY_W  key to hash.
REQ-009 req_ready  output  1  controller can accept a request.
REQ-010 resp_valid  output  1  response present.
REQ-011 resp_ready  input  1  requester accepts the response.
REQ-012 resp_hit  output  1  query: key possibly present; insert/delete: operation applied.
REQ-013 resp_ovf  output  1  insert aborted because a target cell reports overflow.
REQ-014 resp_err  output  1  delete of an absent key, or reserved opcode.
REQ-015 cnt_addr  output  ADDR_W  selects the counter cell.
REQ-016 cnt_we  output  1  cell WE: 1 = change, 0 = probe.
REQ-017 cnt_inc  output  1  cell Increment: 1 = ++, 0 = --; meaningful only when cnt_we=1.
REQ-018 cnt_zero  input  1  Zero output of the addressed cell, combinational.
REQ-019 cnt_of  input  1  OF output of the addressed cell, combinational.

Function
REQ-020 FSM states SHALL be IDLE, HASH, PROBE, UPDATE and RESP.
REQ-021 IDLE: req_ready=1; on req_valid, latch op/key; go to RESP with resp_err=1 for op 11, otherwise go to HASH.
REQ-022 HASH (1 cycle): register h0=key[5:0]^key[11:6], h1=key[11:6]^{key[15:12],key[1:0]}, h2=(key[5:0]+key[15:10]) mod 64.
REQ-023 PROBE (K cycles, i=0..2): cnt_addr=h_i, cnt_we=0; sample cnt_zero/cnt_of in the same cycle and OR them into any_zero/any_of.
REQ-024 After PROBE, query: go to RESP with resp_hit = !any_zero.
REQ-025 After PROBE, insert: if any_of, go to RESP with resp_ovf=1 and no cell change; else go to UPDATE with cnt_inc=1.
REQ-026 After PROBE, delete: if any_zero, go to RESP with resp_err=1 and no cell change; else go to UPDATE with cnt_inc=0.
REQ-027 UPDATE (K cycles): cnt_addr=h_i, cnt_we=1, one cell per cycle; then go to RESP with resp_hit=1.
REQ-028 Colliding indices SHALL each be applied, so a duplicated cell moves twice; cell saturation is handled by the cell.
REQ-029 RESP: resp_valid=1 with flags held stable until resp_ready=1; then go to IDLE; req_ready=0 in every state except IDLE.
REQ-030 Latency from the accept cycle t: query or abort resp_valid at t+5; insert/delete success at t+8; reserved opcode at t+1.
REQ-031 cnt_we SHALL be 0 in every state except UPDATE; cnt_addr=0 when no cell is addressed.
REQ-032 Exactly one of resp_hit/resp_ovf/resp_err may be 1, except a query miss, which has all three at 0.

Reset
REQ-033 rstb=1 SHALL force IDLE asynchronously, including mid-PROBE or mid-UPDATE; a partial update is not rolled back.
REQ-034 Reset values: req_ready=1, resp_valid=0, resp_hit=0, resp_ovf=0, resp_err=0, cnt_we=0, cnt_inc=0, cnt_addr=0; hash and flag registers 0.

Structure
REQ-035 Package cbf_pkg SHALL hold the opcode constants, the FSM state encoding, and the KEY_W/ADDR_W/K defaults.
REQ-036 Sub-module cbf_hash_gen SHALL hold the three combinational hash functions (key in, h0..h2 out); the controller registers its outputs in HASH.

Verification
REQ-037 Reset, then insert key 0x1234 -> UPDATE addresses 60, 12, 56 with cnt_we=1, cnt_inc=1; resp_hit=1 at t+8.
REQ-038 Query 0x1234 after that insert -> no cnt_we pulse; resp_hit=1 at t+5; query of a fresh key on an all-zero array -> all flags 0.
REQ-039 Delete 0x1234 on an empty array -> resp_err=1 at t+5 with no cnt_we pulse; delete after one insert -> resp_hit=1 and cells return to their zero state.
REQ-040 Force cnt_of=1 while probing address 12 on insert -> resp_ovf=1 at t+5 and cnt_we never asserted.
REQ-041 Hold resp_ready=0 for 4 cycles -> resp_valid and flags stay stable and req_ready stays 0; op 11 -> resp_err=1 at t+1.
REQ-042 Assert rstb during the second UPDATE cycle -> IDLE at once, all outputs at reset values, and the next request is accepted normally.
